// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage RV32 pipeline: M/W forwarding, load-use stall,
// branch flush, multi-cycle execute freeze and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int LAT_W = 6,
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_d_rs1,
  input  logic [REG_W-1:0] i_d_rs2,
  input  logic             i_d_use_rs1,
  input  logic             i_d_use_rs2,
  input  logic [REG_W-1:0] i_e_rs1,
  input  logic [REG_W-1:0] i_e_rs2,
  input  logic [REG_W-1:0] i_e_rd,
  input  logic             i_e_is_load,
  input  logic             i_e_mc_start,
  input  logic [LAT_W-1:0] i_e_mc_lat,
  input  logic             i_e_pc_src,
  input  logic [REG_W-1:0] i_m_rd,
  input  logic [REG_W-1:0] i_w_rd,
  input  logic             i_m_regwrite,
  input  logic             i_w_regwrite,
  input  logic             i_cnt_clr,
  output logic [1:0]       o_fwd_a,
  output logic [1:0]       o_fwd_b,
  output logic             o_f_stall,
  output logic             o_fd_stall,
  output logic             o_de_stall,
  output logic             o_fd_flush,
  output logic             o_de_flush,
  output logic             o_em_flush,
  output logic             o_mc_busy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [LAT_W-1:0] rem;
  logic             mc_accept;
  logic             mc_raw;
  logic             lw_raw;
  logic             mc_stall;
  logic             lw_stall;
  logic             branch;

  // M result is younger than W, so it wins; x0 is hardwired and never forwards.
  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] m_rd,
                                         input logic             m_we,
                                         input logic [REG_W-1:0] w_rd,
                                         input logic             w_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (rs != '0 && m_we && m_rd == rs)      sel = 2'b10;
    else if (rs != '0 && w_we && w_rd == rs) sel = 2'b01;
    return sel;
  endfunction

  assign o_fwd_a = fwd_sel(i_e_rs1, i_m_rd, i_m_regwrite, i_w_rd, i_w_regwrite);
  assign o_fwd_b = fwd_sel(i_e_rs2, i_m_rd, i_m_regwrite, i_w_rd, i_w_regwrite);

  assign lw_raw = i_e_is_load && (i_e_rd != '0) &&
                  ((i_d_use_rs1 && i_d_rs1 == i_e_rd) ||
                   (i_d_use_rs2 && i_d_rs2 == i_e_rd));

  assign mc_accept = (state == IDLE) && i_e_mc_start && (i_e_mc_lat >= LAT_W'(2));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mc_raw = 1'b0;
    case (state)
      IDLE:    mc_raw = mc_accept;
      BUSY:    mc_raw = 1'b1;
      default: mc_raw = 1'b0;
    endcase
  end

  // Everything is held quiet while reset is asserted, regardless of inputs.
  assign mc_stall = i_rst & mc_raw;
  assign lw_stall = i_rst & lw_raw;
  assign branch   = i_rst & i_e_pc_src;

  assign o_f_stall  = lw_stall | mc_stall;
  assign o_fd_stall = lw_stall | mc_stall;
  assign o_de_stall = mc_stall;
  assign o_em_flush = mc_stall;
  assign o_fd_flush = branch & ~mc_stall;
  assign o_de_flush = (lw_stall | branch) & ~mc_stall;
  assign o_mc_busy  = mc_stall;

  // The accepting IDLE cycle is the first stall, so BUSY covers lat-2 more.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_accept) begin
            if (i_e_mc_lat == LAT_W'(2)) begin
              state <= DONE;
            end else begin
              rem   <= i_e_mc_lat - LAT_W'(2);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (rem == LAT_W'(1)) state <= DONE;
          else                  rem   <= rem - LAT_W'(1);
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_stall_cnt <= '0;
    end else if (i_cnt_clr) begin
      o_stall_cnt <= '0;
    end else if (o_f_stall && o_stall_cnt != {CNT_W{1'b1}}) begin
      o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

endmodule
